// File: rtl/cram_req_bridge_pkg.sv
// Shared types and defaults for the CRAM request bridge.
// The FSM state encoding, parameter defaults and the half-word address helper live here.
package cram_req_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_SEL  = 3'd2,
        ST_NEXT = 3'd3,
        ST_RESP = 3'd4
    } bridge_state_t;

    localparam int SEL_GAP_DEFAULT = 2;
    localparam int TMO_CYC_DEFAULT = 255;

    localparam logic [23:0] HALF_STRIDE = 24'd2;

    // Byte address of the low (hi=0) or high (hi=1) half; the 24-bit add wraps,
    // and carrying into bit 23 deliberately moves the high half to the other chip.
    function automatic logic [23:0] half_addr(input logic [23:0] addr, input logic hi);
        logic [23:0] base;
        base = {addr[23:1], 1'b0};
        if (hi) begin
            return base + HALF_STRIDE;
        end else begin
            return base;
        end
    endfunction

endpackage

// File: rtl/cram_req_bridge_ack_edge.sv
// cram_ack_edge: registers the controller's Sln_xferAck and flags its rising edge.
// The controller leaves ack high until the next access starts, so only a fresh
// rise may complete a half.
module cram_ack_edge (
    input  logic OPB_Clk,
    input  logic OPB_Rst,
    input  logic i_ack,
    output logic o_ack_rise
);

    logic r_ack_q;

    // Remember last cycle's ack level so a level left over from before is ignored
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            r_ack_q <= 1'b0;
        end else begin
            r_ack_q <= i_ack;
        end
    end

    assign o_ack_rise = i_ack & ~r_ack_q;

endmodule

// File: rtl/cram_req_bridge.sv
// cram_req_bridge: turns one 16/32-bit core request into one or two half-word
// accesses on the OPB CRAM controller interface and returns a one-cycle response.
// Optional feature macro: CRAM_BRIDGE_TMO_EN enables a per-half SEL watchdog
// (TMO_CYC cycles) that aborts the access and reports rsp_err.
module cram_req_bridge
    import cram_req_bridge_pkg::*;
#(
    parameter int SEL_GAP = SEL_GAP_DEFAULT,
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_wide,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [23:0] OPB_ABus,
    output logic [15:0] OPB_DBus,
    output logic [1:0]  OPB_BE,
    output logic        OPB_RNW,
    output logic        OPB_32Bit,
    output logic        OPB_select,
    input  logic [15:0] Sln_DBus,
    input  logic        Sln_xferAck
);

    bridge_state_t r_state;
    bridge_state_t w_state_nxt;

    logic        r_req_ready;
    logic        r_select;
    logic        r_rsp_valid;
    logic        w_ready_nxt;
    logic        w_select_nxt;
    logic        w_rsp_valid_nxt;

    logic [3:0]  r_gap_cnt;
    logic        w_gap_done;
    logic        w_accept;
    logic        w_ack_rise;
    logic        w_tmo_hit;

    logic        r_write;
    logic        r_wide;
    logic        r_half;
    logic [23:0] r_hi_addr;
    logic [15:0] r_hi_data;
    logic [1:0]  r_hi_be;

    logic [23:0] r_abus;
    logic [15:0] r_dbus;
    logic [1:0]  r_be;
    logic        r_rnw;
    logic        r_32bit;
    logic [31:0] r_rdata;

    logic        w_unused_addr0;

    assign w_unused_addr0 = req_addr[0];
    assign w_accept       = req_valid & r_req_ready;
    assign w_gap_done     = (r_gap_cnt == 4'(SEL_GAP - 1));

    cram_ack_edge u_ack_edge (
        .OPB_Clk    (OPB_Clk),
        .OPB_Rst    (OPB_Rst),
        .i_ack      (Sln_xferAck),
        .o_ack_rise (w_ack_rise)
    );

    // State register, with the state-decoded outputs registered alongside it
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_select    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_ready_nxt;
            r_select    <= w_select_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    // Next-state logic: gap, select until a fresh ack edge (or watchdog), then next half or respond
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = ST_SEL;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_SEL: begin
                if (w_ack_rise) begin
                    w_state_nxt = ST_NEXT;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_SEL;
                end
            end
            ST_NEXT: begin
                if (r_wide && !r_half) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so ready/select/rsp_valid are registered and track the state exactly
    always_comb begin
        w_ready_nxt     = 1'b0;
        w_select_nxt    = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        case (w_state_nxt)
            ST_IDLE: w_ready_nxt     = 1'b1;
            ST_SEL:  w_select_nxt    = 1'b1;
            ST_RESP: w_rsp_valid_nxt = 1'b1;
            default: w_ready_nxt     = 1'b0;
        endcase
    end

    // Count GAP cycles so OPB_select is low for SEL_GAP cycles before every rise
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            r_gap_cnt <= 4'd0;
        end else if (r_state == ST_GAP) begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
        end else begin
            r_gap_cnt <= 4'd0;
        end
    end

    // Latch the request, steer each half onto the bus (held from GAP through SEL), collect read halves
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            r_write   <= 1'b0;
            r_wide    <= 1'b0;
            r_half    <= 1'b0;
            r_hi_addr <= 24'd0;
            r_hi_data <= 16'd0;
            r_hi_be   <= 2'b00;
            r_abus    <= 24'd0;
            r_dbus    <= 16'd0;
            r_be      <= 2'b11;
            r_rnw     <= 1'b1;
            r_32bit   <= 1'b0;
            r_rdata   <= 32'd0;
        end else if (w_accept) begin
            r_write   <= req_write;
            r_wide    <= req_wide;
            r_half    <= 1'b0;
            r_hi_addr <= half_addr(req_addr, 1'b1);
            r_hi_data <= req_wdata[31:16];
            r_hi_be   <= req_be[3:2];
            r_abus    <= half_addr(req_addr, 1'b0);
            r_dbus    <= req_wdata[15:0];
            r_be      <= req_be[1:0];
            r_rnw     <= ~req_write;
            r_32bit   <= req_wide;
            r_rdata   <= 32'd0;
        end else if ((r_state == ST_SEL) && w_ack_rise && !r_write) begin
            if (r_half) begin
                r_rdata[31:16] <= Sln_DBus;
            end else begin
                r_rdata[15:0]  <= Sln_DBus;
            end
        end else if ((r_state == ST_NEXT) && r_wide && !r_half) begin
            r_half <= 1'b1;
            r_abus <= r_hi_addr;
            r_dbus <= r_hi_data;
            r_be   <= r_hi_be;
        end else begin
            r_half <= r_half;
        end
    end

`ifdef CRAM_BRIDGE_TMO_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    assign w_tmo_hit = (r_state == ST_SEL) && (r_tmo_cnt == TMO_W'(TMO_CYC - 1));

    // Per-half watchdog: counts cycles waiting in SEL, cleared whenever SEL is left
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if ((r_state == ST_SEL) && !w_ack_rise) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end
    end

    // Error flag: cleared on a new request, set when the watchdog aborts a half
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_tmo_hit && !w_ack_rise) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign rsp_err = r_err;
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TMO_CYC > 0);
    assign w_tmo_hit    = 1'b0;
    assign rsp_err      = 1'b0;
`endif

    assign req_ready  = r_req_ready;
    assign OPB_select = r_select;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rdata;
    assign OPB_ABus   = r_abus;
    assign OPB_DBus   = r_dbus;
    assign OPB_BE     = r_be;
    assign OPB_RNW    = r_rnw;
    assign OPB_32Bit  = r_32bit;

endmodule

// File: tb/tb_cram_req_bridge.sv
// Self-checking bench for cram_req_bridge: a behavioural CRAM controller answers
// each select rise after a random delay, and every response is compared against
// the half-word split, latency and read data expected from the request.
module tb_cram_req_bridge;

    localparam int G   = 3;
    localparam int TMO = 8;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_wide = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = 24'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [23:0] OPB_ABus;
    logic [15:0] OPB_DBus;
    logic [1:0]  OPB_BE;
    logic        OPB_RNW, OPB_32Bit, OPB_select;
    logic [15:0] Sln_DBus = 16'd0;
    logic        Sln_xferAck = 1'b0;

    cram_req_bridge #(.SEL_GAP(G), .TMO_CYC(TMO)) dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .OPB_ABus(OPB_ABus), .OPB_DBus(OPB_DBus), .OPB_BE(OPB_BE), .OPB_RNW(OPB_RNW),
        .OPB_32Bit(OPB_32Bit), .OPB_select(OPB_select),
        .Sln_DBus(Sln_DBus), .Sln_xferAck(Sln_xferAck)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    int cyc = 0;
    always @(posedge OPB_Clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int acc_cyc = 0;

    typedef struct {
        logic [23:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        logic        rnw;
        logic        b32;
        int          dly;
        logic [15:0] rd;
        bit          stable;
    } acc_t;

    acc_t        acc_q[$];
    logic [15:0] rd_force[$];
    bit          ctrl_stall = 1'b0;

    // Behavioural controller: on each select rise drop ack, wait dly cycles, raise ack with data
    acc_t ctl_cur;
    bit   ctl_prev = 1'b0;
    bit   ctl_pend = 1'b0;
    int   ctl_cnt  = 0;
    initial begin
        forever begin
            @(posedge OPB_Clk); #1;
            if (OPB_select && !ctl_prev) begin
                ctl_cur.a = OPB_ABus; ctl_cur.d = OPB_DBus; ctl_cur.be = OPB_BE;
                ctl_cur.rnw = OPB_RNW; ctl_cur.b32 = OPB_32Bit; ctl_cur.stable = 1'b1;
                ctl_cur.dly = int'($urandom_range(1, 4));
                if (rd_force.size() > 0) ctl_cur.rd = rd_force.pop_front();
                else ctl_cur.rd = 16'($urandom);
                Sln_xferAck = 1'b0;
                ctl_cnt = ctl_cur.dly;
                if (ctrl_stall) begin
                    ctl_cur.dly = -1;
                    acc_q.push_back(ctl_cur);
                    ctl_pend = 1'b0;
                end else begin
                    ctl_pend = 1'b1;
                end
            end else if (ctl_pend) begin
                if (OPB_ABus !== ctl_cur.a || OPB_DBus !== ctl_cur.d || OPB_BE !== ctl_cur.be ||
                    OPB_RNW !== ctl_cur.rnw || OPB_32Bit !== ctl_cur.b32 || OPB_select !== 1'b1)
                    ctl_cur.stable = 1'b0;
                ctl_cnt--;
                if (ctl_cnt == 0) begin
                    Sln_xferAck = 1'b1;
                    Sln_DBus = ctl_cur.rd;
                    ctl_pend = 1'b0;
                    acc_q.push_back(ctl_cur);
                end
            end
            ctl_prev = OPB_select;
        end
    end

    // Present a request (caller is at a negedge) and wait for it to be accepted
    task automatic start_req(input bit w, input bit wd, input logic [23:0] a,
                             input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        req_write = w; req_wide = wd; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            @(negedge OPB_Clk); n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL accept_wait: req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
        end else begin
            acc_cyc = cyc;
            @(posedge OPB_Clk); #1;
            req_valid = 1'b0;
        end
    endtask

    // Wait for the response and check it against the request-derived expectation; ends at a negedge
    task automatic finish_req(input bit w, input bit wd, input logic [23:0] a,
                              input logic [31:0] d, input logic [3:0] be, input bit exp_err);
        int n = 0; bit busy_rdy = 1'b0; int nh; int lat_exp; int lat;
        logic [23:0] lo, hi, ea; logic [15:0] ed; logic [1:0] eb; logic [31:0] rd_exp;
        @(negedge OPB_Clk);
        while (rsp_valid !== 1'b1 && n < 400) begin
            if (req_ready === 1'b1) busy_rdy = 1'b1;
            @(negedge OPB_Clk); n++;
        end
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++; $display("FAIL rsp_wait: rsp_valid=%b required 1", rsp_valid);
            acc_q.delete();
            return;
        end
        lat = cyc - acc_cyc;
        total++;
        if (busy_rdy) begin bad++; $display("FAIL busy_ready: req_ready=1 required 0 while busy"); end
        nh = exp_err ? 1 : (wd ? 2 : 1);
        total++;
        if (acc_q.size() != nh) begin
            bad++; $display("FAIL half_count: got %0d required %0d", acc_q.size(), nh);
        end
        lo = a & 24'hFFFFFE;
        hi = lo + 24'd2;
        lat_exp = exp_err ? (G + TMO + 1) : 1;
        for (int k = 0; k < nh && k < acc_q.size(); k++) begin
            ea = (k == 0) ? lo : hi;
            ed = (k == 0) ? d[15:0] : d[31:16];
            eb = (k == 0) ? be[1:0] : be[3:2];
            if (!exp_err) lat_exp += G + acc_q[k].dly + 2;
            total++;
            if (acc_q[k].a !== ea) begin bad++; $display("FAIL half%0d_addr: got %h required %h", k, acc_q[k].a, ea); end
            total++;
            if (acc_q[k].d !== ed) begin bad++; $display("FAIL half%0d_data: got %h required %h", k, acc_q[k].d, ed); end
            total++;
            if (acc_q[k].be !== eb) begin bad++; $display("FAIL half%0d_be: got %b required %b", k, acc_q[k].be, eb); end
            total++;
            if (acc_q[k].rnw !== !w) begin bad++; $display("FAIL half%0d_rnw: got %b required %b", k, acc_q[k].rnw, !w); end
            total++;
            if (acc_q[k].b32 !== wd) begin bad++; $display("FAIL half%0d_32bit: got %b required %b", k, acc_q[k].b32, wd); end
            total++;
            if (acc_q[k].stable !== 1'b1) begin bad++; $display("FAIL half%0d_stable: got 0 required 1", k); end
        end
        total++;
        if (lat != lat_exp) begin bad++; $display("FAIL latency: got %0d required %0d", lat, lat_exp); end
        if (!w) begin
            rd_exp = 32'd0;
            if (!exp_err && acc_q.size() >= 1) rd_exp[15:0] = acc_q[0].rd;
            if (!exp_err && wd && acc_q.size() >= 2) rd_exp[31:16] = acc_q[1].rd;
            total++;
            if (rsp_rdata !== rd_exp) begin bad++; $display("FAIL rdata: got %h required %h", rsp_rdata, rd_exp); end
        end
        total++;
        if (rsp_err !== exp_err) begin bad++; $display("FAIL rsp_err: got %b required %b", rsp_err, exp_err); end
        @(negedge OPB_Clk);
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_pulse: rsp_valid=%b required 0", rsp_valid); end
        acc_q.delete();
    endtask

    task automatic txn(input bit w, input bit wd, input logic [23:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        start_req(w, wd, a, d, be);
        finish_req(w, wd, a, d, be, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge OPB_Clk);
        total++;
        if ({OPB_select, req_ready, rsp_valid, rsp_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b required 0000", {OPB_select, req_ready, rsp_valid, rsp_err});
        end
        total++;
        if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h required 0", rsp_rdata); end
        total++;
        if ({OPB_ABus, OPB_DBus, OPB_BE, OPB_RNW, OPB_32Bit} !== {24'd0, 16'd0, 2'b11, 1'b1, 1'b0}) begin
            bad++; $display("FAIL reset_bus: got %h %h %b %b %b required 000000 0000 11 1 0",
                            OPB_ABus, OPB_DBus, OPB_BE, OPB_RNW, OPB_32Bit);
        end
        OPB_Rst = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL ready_pre_clk: got %b required 0", req_ready); end
        @(posedge OPB_Clk); #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_post_rst: got %b required 1", req_ready); end
        @(negedge OPB_Clk);
    endtask

    task automatic test_wide_write();
        txn(1'b1, 1'b1, 24'h000100, 32'hDEADBEEF, 4'hF);
    endtask

    task automatic test_wide_read();
        rd_force.push_back(16'h1234);
        rd_force.push_back(16'h5678);
        txn(1'b0, 1'b1, 24'h800010, 32'h0, 4'hF);
    endtask

    task automatic test_stale_ack_narrow_read();
        txn(1'b1, 1'b0, 24'h000200, 32'h0000AAAA, 4'h3);
        txn(1'b0, 1'b0, 24'h000201, 32'hFFFF5555, 4'h3);
    endtask

    task automatic test_wrap();
        txn(1'b1, 1'b1, 24'hFFFFFE, 32'hCAFEF00D, 4'h9);
        txn(1'b0, 1'b1, 24'h7FFFFE, 32'h0, 4'hF);
    endtask

    task automatic test_back_to_back();
        start_req(1'b1, 1'b1, 24'h123456, 32'h11112222, 4'hF);
        req_write = 1'b0; req_wide = 1'b1; req_addr = 24'h00ABC0; req_wdata = 32'h0; req_be = 4'hC;
        req_valid = 1'b1;
        finish_req(1'b1, 1'b1, 24'h123456, 32'h11112222, 4'hF, 1'b0);
        txn(1'b0, 1'b1, 24'h00ABC0, 32'h0, 4'hC);
    endtask

    task automatic test_random();
        bit w, wd; logic [23:0] a; logic [31:0] d; logic [3:0] be;
        for (int i = 0; i < 24; i++) begin
            w  = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            d  = $urandom;
            be = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 24'hFFFFFE | 24'($urandom_range(0, 1));
                1:       a = 24'h7FFFFE;
                default: a = 24'($urandom);
            endcase
            txn(w, wd, a, d, be);
        end
    endtask

`ifdef CRAM_BRIDGE_TMO_EN
    task automatic test_timeout();
        ctrl_stall = 1'b1;
        start_req(1'b0, 1'b1, 24'h004000, 32'h0, 4'hF);
        finish_req(1'b0, 1'b1, 24'h004000, 32'h0, 4'hF, 1'b1);
        ctrl_stall = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_sel();
        int n = 0; bit seen = 1'b0;
        start_req(1'b1, 1'b1, 24'h000400, 32'h12345678, 4'hF);
        while (OPB_select !== 1'b1 && n < 50) begin @(negedge OPB_Clk); n++; end
        total++;
        if (OPB_select !== 1'b1) begin bad++; $display("FAIL sel_wait: OPB_select=%b required 1", OPB_select); end
        #2 OPB_Rst = 1'b0;
        #1;
        total++;
        if ({OPB_select, rsp_valid, req_ready} !== 3'b000) begin
            bad++; $display("FAIL mid_rst: sel/rsp/ready=%b required 000", {OPB_select, rsp_valid, req_ready});
        end
        repeat (2) @(negedge OPB_Clk);
        OPB_Rst = 1'b1;
        @(posedge OPB_Clk); #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b required 1", req_ready); end
        repeat (10) begin
            @(negedge OPB_Clk);
            if (rsp_valid === 1'b1 || OPB_select === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL mid_rst_abort: response or select seen after reset, required none"); end
        acc_q.delete();
    endtask

    initial begin
        test_reset();
        test_wide_write();
        test_wide_read();
        test_stale_ack_narrow_read();
        test_wrap();
        test_back_to_back();
        test_random();
`ifdef CRAM_BRIDGE_TMO_EN
        test_timeout();
`endif
        test_reset_mid_sel();
        test_stale_ack_narrow_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
